// File: rtl/sdram_chip_model_if.sv
// sdram_chip_model_if
// Command/data bus between the 8-cycle SDR SDRAM controller (master) and the
// SDRAM responder model (slave).
//   sd_cs/sd_ras/sd_cas/sd_we : active-low command strobes, sampled every posedge
//   sd_ba, sd_addr            : bank and multiplexed row/column/mode address
//   sd_dqm                    : byte masks, 1 = lane masked
//   sd_data_in, sd_data_dir   : write data and "controller drives the bus"
//   sd_data_out, sd_data_oe   : read data and "model drives the bus"
//
// Bus timing: there is no valid/ready pair. The master presents one command
// per clock and the slave always accepts it on that posedge. Read data answers
// a READ sampled at edge T: sd_data_oe is high and sd_data_out holds the word
// between edges T+CL-1 and T+CL, so the master captures it at edge T+CL.
// Only one side may drive data on a cycle; both driving is a contention.
interface sdram_chip_model_if #(
    parameter int NBANK_BITS = 1
);
    logic                  sd_cs;
    logic                  sd_ras;
    logic                  sd_cas;
    logic                  sd_we;
    logic [NBANK_BITS-1:0] sd_ba;
    logic [10:0]           sd_addr;
    logic [1:0]            sd_dqm;
    logic [15:0]           sd_data_in;
    logic                  sd_data_dir;
    logic [15:0]           sd_data_out;
    logic                  sd_data_oe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm,
               sd_data_in, sd_data_dir,
        input  sd_data_out, sd_data_oe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm,
               sd_data_in, sd_data_dir,
        output sd_data_out, sd_data_oe
    );
endinterface

// File: rtl/sdram_chip_model.sv
// sdram_chip_model
// Synthesizable single-rank 16-bit SDR SDRAM responder. Decodes commands,
// tracks per-bank open rows and tRCD, holds the mode register, stores data in
// an aliased internal array and raises sticky protocol error flags.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   bus (slave)     : SDRAM command/data bus (see sdram_chip_model_if)
//   mode_reg        : last accepted LOAD_MODE value
//   mode_valid      : a LOAD_MODE has been accepted since reset
//   refresh_count   : AUTO_REFRESH commands seen, wrapping
//   err_flags       : sticky [0] cmd before mode, [1] rd/wr idle bank,
//                     [2] ACTIVE to open bank, [3] tRCD, [4] bus contention,
//                     [5] mode/refresh with bank open or bad CL
//   bank_active_dbg : per-bank FSM state (1 = ACTIVE)
// The interface NBANK_BITS parameter must match this module's NBANK_BITS.
module sdram_chip_model #(
    parameter int MEM_AW     = 12,
    parameter int TRCD       = 2,
    parameter int NBANK_BITS = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    sdram_chip_model_if.slave           bus,
    output logic [10:0]                 mode_reg,
    output logic                        mode_valid,
    output logic [15:0]                 refresh_count,
    output logic [5:0]                  err_flags,
    output logic [(1<<NBANK_BITS)-1:0]  bank_active_dbg
);
    localparam int NBANK = 1 << NBANK_BITS;

    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    bank_state_t bank_state [NBANK];
    logic [10:0] bank_row   [NBANK];
    logic [2:0]  trcd_cnt   [NBANK];

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    // Read pipeline: two delay stages feeding the registered output stage.
    logic [1:0]  pipe_v;
    logic [15:0] pipe_d [2];
    logic [15:0] data_out_q;
    logic        oe_q;

    logic [3:0]        cmd;
    logic              sel_active;
    logic              trcd_short;
    logic              any_open;
    logic              cl3;
    logic              mode_cl_ok;
    logic [MEM_AW-1:0] word_addr;
    logic [15:0]       stored;
    logic [15:0]       rd_word;

    assign cmd        = {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we};
    assign sel_active = (bank_state[bus.sd_ba] == BANK_ACTIVE);
    assign trcd_short = (trcd_cnt[bus.sd_ba] < 3'(TRCD - 1));
    // Anything other than CL=3 behaves as CL=2, including the reset value 0.
    assign cl3        = (mode_reg[6:4] == 3'd3);
    assign mode_cl_ok = (bus.sd_addr[6:4] == 3'd2) || (bus.sd_addr[6:4] == 3'd3);
    // {ba,row,col} truncated: higher address bits alias onto the same word.
    assign word_addr  = MEM_AW'({bus.sd_ba, bank_row[bus.sd_ba], bus.sd_addr[7:0]});
    assign stored     = mem[word_addr];
    assign rd_word    = sel_active ? {bus.sd_dqm[1] ? 8'h00 : stored[15:8],
                                      bus.sd_dqm[0] ? 8'h00 : stored[7:0]}
                                   : 16'h0000;

    assign bus.sd_data_out = data_out_q;
    assign bus.sd_data_oe  = oe_q;

    always_comb begin
        any_open        = 1'b0;
        bank_active_dbg = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (bank_state[b] == BANK_ACTIVE) begin
                any_open           = 1'b1;
                bank_active_dbg[b] = 1'b1;
            end
        end
    end

    // Storage is not reset. The read path sees the pre-edge contents, so a
    // read never observes a write from the same edge.
    always_ff @(posedge clk) begin
        if (!reset && cmd == CMD_WRITE && sel_active) begin
            if (!bus.sd_dqm[0]) mem[word_addr][7:0]  <= bus.sd_data_in[7:0];
            if (!bus.sd_dqm[1]) mem[word_addr][15:8] <= bus.sd_data_in[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANK; b++) begin
                bank_state[b] <= BANK_IDLE;
                bank_row[b]   <= '0;
                trcd_cnt[b]   <= '0;
            end
            pipe_v        <= '0;
            pipe_d[0]     <= '0;
            pipe_d[1]     <= '0;
            data_out_q    <= '0;
            oe_q          <= 1'b0;
            mode_reg      <= '0;
            mode_valid    <= 1'b0;
            refresh_count <= '0;
            err_flags     <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (trcd_cnt[b] != 3'd7) trcd_cnt[b] <= trcd_cnt[b] + 3'd1;
            end

            // Shift the read pipeline; a new READ below overrides its slot.
            pipe_v[0]  <= pipe_v[1];
            pipe_d[0]  <= pipe_d[1];
            pipe_v[1]  <= 1'b0;
            pipe_d[1]  <= '0;
            oe_q       <= pipe_v[0];
            data_out_q <= pipe_v[0] ? pipe_d[0] : 16'h0000;

            if (bus.sd_data_dir && oe_q) err_flags[4] <= 1'b1;

            case (cmd)
                CMD_ACTIVE: begin
                    if (!mode_valid) err_flags[0] <= 1'b1;
                    if (sel_active)  err_flags[2] <= 1'b1;
                    bank_state[bus.sd_ba] <= BANK_ACTIVE;
                    bank_row[bus.sd_ba]   <= bus.sd_addr;
                    trcd_cnt[bus.sd_ba]   <= '0;
                end
                CMD_READ, CMD_WRITE: begin
                    if (!mode_valid) err_flags[0] <= 1'b1;
                    if (!sel_active) begin
                        err_flags[1] <= 1'b1;
                    end else begin
                        if (trcd_short)     err_flags[3] <= 1'b1;
                        if (bus.sd_addr[10]) bank_state[bus.sd_ba] <= BANK_IDLE;
                    end
                    // Slot chosen so the word reaches the output at T+CL-1.
                    if (cmd == CMD_READ) begin
                        if (cl3) begin
                            pipe_v[1] <= 1'b1;
                            pipe_d[1] <= rd_word;
                        end else begin
                            pipe_v[0] <= 1'b1;
                            pipe_d[0] <= rd_word;
                        end
                    end
                end
                CMD_PRECHARGE: begin
                    if (bus.sd_addr[10]) begin
                        for (int b = 0; b < NBANK; b++) bank_state[b] <= BANK_IDLE;
                    end else begin
                        bank_state[bus.sd_ba] <= BANK_IDLE;
                    end
                end
                CMD_REFRESH: begin
                    if (!mode_valid) err_flags[0] <= 1'b1;
                    if (any_open)    err_flags[5] <= 1'b1;
                    refresh_count <= refresh_count + 16'd1;
                end
                CMD_LOAD_MODE: begin
                    if (any_open) begin
                        err_flags[5] <= 1'b1;
                    end else begin
                        mode_reg   <= bus.sd_addr;
                        mode_valid <= 1'b1;
                        if (!mode_cl_ok) err_flags[5] <= 1'b1;
                    end
                end
                default: ; // NOP, BURST_TERMINATE, INHIBIT
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model
// Directed and randomized bench for sdram_chip_model. A behavioural reference
// model (open rows per bank, word array, CAS latency, queue of due reads)
// predicts every read beat; directed steps cover init, masking, CL2/CL3
// timing, each error flag and reset during a read.
module tb_sdram_chip_model;
    localparam int MEM_AW     = 12;
    localparam int NBANK_BITS = 1;

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_NOP = 4'b0111;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [5:0]  err_flags;
    logic [1:0]  bank_active_dbg;

    sdram_chip_model_if #(.NBANK_BITS(NBANK_BITS)) bus ();

    sdram_chip_model #(.MEM_AW(MEM_AW), .TRCD(2), .NBANK_BITS(NBANK_BITS)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .mode_reg        (mode_reg),
        .mode_valid      (mode_valid),
        .refresh_count   (refresh_count),
        .err_flags       (err_flags),
        .bank_active_dbg (bank_active_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          cyc       = 0;
    int          due_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] m_mem [1<<MEM_AW];
    bit          m_open [2];
    logic [10:0] m_row  [2];
    int          m_cl = 2;

    function automatic int waddr(int ba, logic [10:0] row, logic [7:0] col);
        return ((ba << 19) + (int'(row) << 8) + int'(col)) % (1 << MEM_AW);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_cmd(input logic [3:0] c, input int ba, input logic [10:0] a,
                             input logic [1:0] dqm, input logic [15:0] d);
        logic [15:0] w;
        int          wa;
        case (c)
            C_ACT: begin
                m_open[ba] = 1'b1;
                m_row[ba]  = a;
            end
            C_PRE: begin
                if (a[10]) begin
                    m_open[0] = 1'b0;
                    m_open[1] = 1'b0;
                end else begin
                    m_open[ba] = 1'b0;
                end
            end
            C_WR: begin
                if (m_open[ba]) begin
                    wa = waddr(ba, m_row[ba], a[7:0]);
                    if (!dqm[0]) m_mem[wa][7:0]  = d[7:0];
                    if (!dqm[1]) m_mem[wa][15:8] = d[15:8];
                    if (a[10]) m_open[ba] = 1'b0;
                end
            end
            C_RD: begin
                w = 16'h0000;
                if (m_open[ba]) begin
                    wa = waddr(ba, m_row[ba], a[7:0]);
                    w  = m_mem[wa];
                    if (dqm[0]) w[7:0]  = 8'h00;
                    if (dqm[1]) w[15:8] = 8'h00;
                    if (a[10]) m_open[ba] = 1'b0;
                end
                due_q.push_back(cyc + m_cl - 1);
                exp_q.push_back(w);
            end
            C_LMR: begin
                if (!m_open[0] && !m_open[1]) m_cl = (a[6:4] == 3'd3) ? 3 : 2;
            end
            default: ;
        endcase
    endtask

    // Compares the bus against the model after every edge.
    task automatic check_bus();
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            chk("rd_oe", 32'(bus.sd_data_oe), 1);
            chk("rd_data", 32'(bus.sd_data_out), 32'(exp_q[0]));
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
        end else begin
            chk("idle_oe", 32'(bus.sd_data_oe), 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = C_NOP;
        bus.sd_data_dir = 1'b0;
    endtask

    task automatic step(input logic [3:0] c = C_NOP, input int ba = 0,
                        input logic [10:0] a = 11'h000, input logic [1:0] dqm = 2'b00,
                        input logic [15:0] d = 16'h0000, input logic dir = 1'b0);
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = c;
        bus.sd_ba       = ba[NBANK_BITS-1:0];
        bus.sd_addr     = a;
        bus.sd_dqm      = dqm;
        bus.sd_data_in  = d;
        bus.sd_data_dir = dir;
        @(posedge clk);
        #1;
        cyc++;
        model_cmd(c, ba, a, dqm, d);
        drive_nop();
        check_bus();
    endtask

    task automatic step_rst();
        reset = 1'b1;
        drive_nop();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        m_open[0] = 1'b0;
        m_open[1] = 1'b0;
        m_cl      = 2;
        due_q.delete();
        exp_q.delete();
        check_bus();
    endtask

    task automatic run_random(input int n, input logic [5:0] exp_err);
        logic [7:0]  cols [4];
        logic [10:0] r0, r1;
        int          op, b, k;
        cols[0] = 8'h00; cols[1] = 8'h3C; cols[2] = 8'h81; cols[3] = 8'hFF;
        r0 = 11'($urandom_range(0, 2047));
        r1 = 11'($urandom_range(0, 2047));
        step(C_PRE, 0, 11'h400);
        step(C_ACT, 0, r0);
        step(C_ACT, 1, r1);
        step();
        step();
        for (int bb = 0; bb < 2; bb++)
            for (int kk = 0; kk < 4; kk++)
                step(C_WR, bb, {3'b000, cols[kk]}, 2'b00, 16'($urandom));
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 2));
            b  = int'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 3));
            case (op)
                0:       step(C_WR, b, {3'b000, cols[k]}, 2'($urandom), 16'($urandom));
                1:       step(C_RD, b, {3'b000, cols[k]}, 2'($urandom));
                default: step();
            endcase
        end
        repeat (4) step();
        chk("rand_err", 32'(err_flags), 32'(exp_err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = 4'b1111;
        bus.sd_ba       = '0;
        bus.sd_addr     = '0;
        bus.sd_dqm      = '0;
        bus.sd_data_in  = '0;
        bus.sd_data_dir = 1'b0;

        step_rst();
        step_rst();
        chk("rst_oe",    32'(bus.sd_data_oe), 0);
        chk("rst_dout",  32'(bus.sd_data_out), 0);
        chk("rst_mode",  32'(mode_reg), 0);
        chk("rst_mv",    32'(mode_valid), 0);
        chk("rst_ref",   32'(refresh_count), 0);
        chk("rst_err",   32'(err_flags), 0);
        chk("rst_banks", 32'(bank_active_dbg), 0);

        // ACTIVE before any LOAD_MODE
        step(C_ACT, 0, 11'h001);
        chk("no_mode_err0", 32'(err_flags), 'h01);
        step_rst();
        chk("err_cleared", 32'(err_flags), 0);

        // Init
        step(C_PRE, 0, 11'h400);
        step(C_LMR, 0, 11'h220);
        chk("init_mode", 32'(mode_reg), 'h220);
        chk("init_mv",   32'(mode_valid), 1);
        chk("init_err",  32'(err_flags), 0);

        // Write with auto-precharge, then CL2 read
        step(C_ACT, 1, 11'h05A);
        step();
        step(C_WR, 1, 11'h43C, 2'b00, 16'hBEEF);
        chk("ap_idle", 32'(bank_active_dbg), 0);
        step(C_ACT, 1, 11'h05A);
        step();
        step(C_RD, 1, 11'h03C);
        chk("cl2_T0_oe", 32'(bus.sd_data_oe), 0);
        step();
        chk("cl2_T2_oe",   32'(bus.sd_data_oe), 1);
        chk("cl2_T2_data", 32'(bus.sd_data_out), 'hBEEF);
        step();
        chk("cl2_T3_oe", 32'(bus.sd_data_oe), 0);
        chk("cl2_err",   32'(err_flags), 0);

        // Byte masks
        step(C_WR, 1, 11'h03C, 2'b01, 16'h1234);
        step(C_RD, 1, 11'h03C, 2'b00);
        step();
        chk("mask_wr_data", 32'(bus.sd_data_out), 'h12EF);
        step(C_RD, 1, 11'h03C, 2'b10);
        step();
        chk("mask_rd_data", 32'(bus.sd_data_out), 'h00EF);
        step();

        // CL3
        step(C_PRE, 0, 11'h400);
        step(C_LMR, 0, 11'h230);
        chk("cl3_mode", 32'(mode_reg), 'h230);
        step(C_ACT, 1, 11'h05A);
        step();
        step(C_RD, 1, 11'h03C);
        step();
        chk("cl3_T2_oe", 32'(bus.sd_data_oe), 0);
        step();
        chk("cl3_T3_oe",   32'(bus.sd_data_oe), 1);
        chk("cl3_T3_data", 32'(bus.sd_data_out), 'h12EF);
        step();
        chk("cl3_T4_oe", 32'(bus.sd_data_oe), 0);

        // Randomized traffic at CL3, then CL2
        run_random(80, 6'b000000);
        step(C_PRE, 0, 11'h400);
        step(C_LMR, 0, 11'h220);
        run_random(80, 6'b000000);

        // Error flags (sticky, accumulating)
        step(C_PRE, 0, 11'h400);
        step(C_RD, 0, 11'h000);
        chk("err_idle_rd", 32'(err_flags), 'h02);
        step();
        step();
        step(C_ACT, 0, 11'h001);
        chk("bank0_open", 32'(bank_active_dbg), 'h1);
        step(C_RD, 0, 11'h000, 2'b11);
        chk("err_trcd", 32'(err_flags), 'h0A);
        step();
        step();
        step(C_RD, 0, 11'h000, 2'b11);
        repeat (3) step(C_NOP, 0, 11'h000, 2'b00, 16'h0000, 1'b1);
        chk("err_contention", 32'(err_flags), 'h1A);
        step(C_REF);
        chk("err_ref_open", 32'(err_flags), 'h3A);
        chk("ref_cnt1",     32'(refresh_count), 1);
        step(C_ACT, 0, 11'h002);
        chk("err_act_open", 32'(err_flags), 'h3E);
        step(C_PRE, 0, 11'h400);
        step(C_REF);
        chk("ref_cnt2",   32'(refresh_count), 2);
        chk("err_sticky", 32'(err_flags), 'h3E);

        // Reset during a CL3 read
        step(C_LMR, 0, 11'h230);
        step(C_ACT, 0, 11'h001);
        step();
        step();
        step(C_RD, 0, 11'h000, 2'b11);
        step_rst();
        chk("mid_rst_oe",   32'(bus.sd_data_oe), 0);
        chk("mid_rst_err",  32'(err_flags), 0);
        chk("mid_rst_mv",   32'(mode_valid), 0);
        chk("mid_rst_ref",  32'(refresh_count), 0);
        chk("mid_rst_mode", 32'(mode_reg), 0);
        step();
        chk("flush_T2_oe", 32'(bus.sd_data_oe), 0);
        step();

        // Unsupported CL behaves as CL2; LOAD_MODE with a bank open is ignored
        step(C_PRE, 0, 11'h400);
        step(C_LMR, 0, 11'h250);
        chk("badcl_mode", 32'(mode_reg), 'h250);
        chk("badcl_err",  32'(err_flags), 'h20);
        chk("badcl_mv",   32'(mode_valid), 1);
        step(C_ACT, 0, 11'h003);
        step();
        step(C_RD, 0, 11'h000, 2'b11);
        step();
        chk("badcl_oe", 32'(bus.sd_data_oe), 1);
        step();
        step(C_LMR, 0, 11'h230);
        chk("lmr_open_ignored", 32'(mode_reg), 'h250);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sdram_chip_model.md
Name: sdram_chip_model

Overview:
- Synthesizable responder for the single-rank 16-bit SDR SDRAM command interface driven by the team's 8-cycle SDRAM controller.
- Decodes cs/ras/cas/we commands, tracks per-bank row state, the mode register and CAS latency, and stores data in an internal aliased array.
- Flags protocol violations with sticky error bits.
- Used as the device end in simulation benches and in FPGA loopback builds with no physical SDRAM.

Parameters:
MEM_AW, 12, internal storage address width in words; the full address {ba,row,col} is truncated to its low MEM_AW bits (aliasing).
TRCD, 2, minimum number of clock edges from ACTIVE to READ/WRITE on the same bank.
NBANK_BITS, 1, bank address width (two banks).

Ports:
clk  in  1  device clock, same as controller clock
reset  in  1  reset, synchronous, active-high
sd_cs  in  1  chip select, active low
sd_ras  in  1  row strobe, active low
sd_cas  in  1  column strobe, active low
sd_we  in  1  write enable, active low
sd_ba  in  NBANK_BITS  bank address
sd_addr  in  11  multiplexed row/column/mode address
sd_dqm  in  2  byte masks, 1 = masked
sd_data_in  in  16  write data from the controller
sd_data_dir  in  1  controller is driving the data bus
sd_data_out  out  16  read data to the controller
sd_data_oe  out  1  model is driving read data
mode_reg  out  11  last loaded mode register
mode_valid  out  1  LOAD_MODE has been accepted since reset
refresh_count  out  16  number of AUTO_REFRESH commands accepted, wraps at 16'hFFFF->0
err_flags  out  6  sticky: [0] cmd before mode, [1] rd/wr to idle bank, [2] ACTIVE to open bank, [3] tRCD violation, [4] bus contention, [5] illegal mode/refresh with bank open

Behaviour:
- Command decode: cmd={sd_cs,sd_ras,sd_cas,sd_we}, sampled every posedge clk. cs=1 means INHIBIT.
- Encodings: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, BURST_TERMINATE 0110 (treated as NOP), PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000.
- Reset values: sd_data_out=0, sd_data_oe=0, mode_reg=0, mode_valid=0, refresh_count=0, err_flags=0, all banks IDLE, read pipeline empty. Storage contents are not reset.
- A reset asserted mid-read flushes the pipeline; oe drops on the next edge.
- Per-bank FSM with states IDLE and ACTIVE. Each bank holds a row register (11b) and a saturating tRCD counter (3b). ACTIVE loads the row from sd_addr and clears the counter; the counter then increments each edge.
- ACTIVE to an already ACTIVE bank: sets err[2], reloads the row, stays ACTIVE.
- PRECHARGE: addr[10]=1 idles all banks; otherwise idles bank sd_ba. Legal in any state.
- READ/WRITE: column = addr[7:0]; word address = {ba,row,col} truncated to MEM_AW bits.
  - Bank IDLE: sets err[1]; a WRITE is dropped and a READ returns 0.
  - tRCD counter < TRCD-1 at the command edge (fewer than TRCD edges since ACTIVE): sets err[3], but the access still executes.
  - addr[10]=1 (auto-precharge): the bank goes IDLE on the same edge.
- WRITE: on the command edge, lane i is written with sd_data_in lane i when sd_dqm[i]=0. Burst length 1 only.
- READ timing:
  - Read data comes from the storage contents at the command edge; a WRITE on the same edge to the same word is not visible to that READ.
  - The lane mask is the sd_dqm value sampled with the READ; masked lanes return 8'h00.
  - A READ sampled at edge T drives sd_data_out and sets sd_data_oe=1 from edge T+CL-1 until edge T+CL. The controller sampling at edge T+CL sees the data.
  - oe returns to 0 at edge T+CL unless a further read is due then.
  - CL = mode_reg[6:4]. The pipeline is a 3-stage valid/data shift register.
- LOAD_MODE:
  - Requires all banks IDLE; otherwise sets err[5] and is ignored.
  - On acceptance: mode_reg<=sd_addr, mode_valid<=1.
  - CL values other than 2 or 3 set err[5] and are treated as CL=2.
  - The mode may be reloaded at any time.
- AUTO_REFRESH: requires all banks IDLE, otherwise sets err[5]. Always increments refresh_count.
- Any ACTIVE, READ, WRITE or AUTO_REFRESH while mode_valid=0 sets err[0]; the command is still executed. PRECHARGE and NOP never flag.
- err[4] is set on any edge where sd_data_dir=1 and sd_data_oe=1.
- Simultaneous events: a READ issued while an earlier read is still in the pipeline is accepted (back-to-back reads drive consecutive cycles).

Test Plan:
- Init: reset, then PRECHARGE with addr[10]=1, then LOAD_MODE addr=11'h220 -> mode_reg=11'h220, mode_valid=1, err_flags=0.
- Write/read: ACTIVE ba=1 row=11'h05A; wait 2 edges; WRITE col=8'h3C, addr[10]=1, dqm=00, data=16'hBEEF; ACTIVE again; READ col=8'h3C -> data 16'hBEEF with oe=1 exactly at edge T+2, oe=0 at T+3, err_flags=0.
- Byte mask: write 16'h1234 with dqm=01, then read -> 16'h12xx, upper lane written and lower lane keeping its old value; a read with dqm=10 returns 16'h00xx.
- CL3: LOAD_MODE 11'h230, repeat the read -> data valid at edge T+3, not at T+2.
- Errors: READ to an idle bank -> err[1]; READ 1 edge after ACTIVE -> err[3]; ACTIVE without LOAD_MODE after reset -> err[0]; sd_data_dir=1 during the read window -> err[4]; AUTO_REFRESH with a bank open -> err[5] and refresh_count still +1.
- Reset mid-read: reset asserted the edge after READ -> sd_data_oe=0, err_flags=0, mode_valid=0, refresh_count=0.
